// File: rtl/key_pkg.sv
// Shared definitions for the key input path: click FSM state encoding,
// click count width and the default grouping window.
package key_pkg;

  localparam int unsigned CLICK_CNT_W           = 2;
  localparam int unsigned DEFAULT_WINDOW_CYCLES = 3600000;  // 300 ms at 12 MHz

  // Two-state click grouping FSM, kept as plain constants so the encoding
  // matches the legacy netlist bit-for-bit.
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t WAIT = 1'b1;

endpackage

// File: rtl/click_window_timer.sv
// Gap timer for click grouping: counts cycles since the last press and flags
// the final cycle of the window.
module click_window_timer #(
  parameter int unsigned WINDOW_CYCLES = 3600000,
  parameter int unsigned CNT_W         = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] r_count;

  // Count while enabled; clear has priority. The owner clears on expire, so
  // the counter never reaches the wrap point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expire = (r_count == CNT_W'(WINDOW_CYCLES - 1));

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced key presses that arrive within a time window and reports
// each group once as a single, double or triple click.
module key_click_decoder
  import key_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int unsigned CNT_W         = 22,
  parameter int unsigned MAX_CLICKS    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_pulse,
  output logic                   click_valid,
  output logic [CLICK_CNT_W-1:0] click_count,
  output logic                   busy
);

  state_t                 r_state;
  logic [CLICK_CNT_W-1:0] r_presses;
  logic                   r_valid;
  logic [CLICK_CNT_W-1:0] r_count;
  logic                   r_busy;

  state_t                 w_state_nxt;
  logic [CLICK_CNT_W-1:0] w_presses_nxt;
  logic                   w_valid_nxt;
  logic [CLICK_CNT_W-1:0] w_count_nxt;
  logic                   w_clear;
  logic                   w_enable;
  logic                   w_expire;
  logic [CLICK_CNT_W-1:0] w_inc;

  assign w_inc = r_presses + CLICK_CNT_W'(1);

  click_window_timer #(
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_enable),
    .expire (w_expire)
  );

  // Next-state logic: a press always beats a timeout in the same cycle, and a
  // press in IDLE opens a new group even while the previous event is shown.
  always_comb begin
    w_state_nxt   = r_state;
    w_presses_nxt = r_presses;
    w_valid_nxt   = 1'b0;
    w_count_nxt   = '0;
    w_clear       = 1'b0;
    w_enable      = 1'b0;
    if (r_state == IDLE) begin
      if (key_pulse) begin
        w_presses_nxt = CLICK_CNT_W'(1);
        w_clear       = 1'b1;
        w_state_nxt   = WAIT;
      end
    end else begin
      if (key_pulse && (w_inc == CLICK_CNT_W'(MAX_CLICKS))) begin
        w_valid_nxt   = 1'b1;
        w_count_nxt   = CLICK_CNT_W'(MAX_CLICKS);
        w_presses_nxt = '0;
        w_clear       = 1'b1;
        w_state_nxt   = IDLE;
      end else if (key_pulse) begin
        w_presses_nxt = w_inc;
        w_clear       = 1'b1;
      end else if (w_expire) begin
        w_valid_nxt   = 1'b1;
        w_count_nxt   = r_presses;
        w_presses_nxt = '0;
        w_clear       = 1'b1;
        w_state_nxt   = IDLE;
      end else begin
        w_enable      = 1'b1;
      end
    end
  end

  // State, press counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_presses <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presses <= w_presses_nxt;
      r_valid   <= w_valid_nxt;
      r_count   <= w_count_nxt;
      r_busy    <= (w_state_nxt == WAIT);
    end
  end

  assign click_valid = r_valid;
  assign click_count = r_count;
  assign busy        = r_busy;

endmodule
